polygon_edge_streamer: RTL



---
 rtl/polygon_edge_streamer_pkg.sv | 21 ++
 rtl/polygon_edge_streamer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/polygon_edge_streamer_pkg.sv
// Shared environment types: streamer FSM states and the world-space vertex layout.
package polygon_edge_streamer_pkg;

    localparam int unsigned ENV_WORLD_BITS = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        READ = 3'd2,
        CAP  = 3'd3,
        EMIT = 3'd4,
        DONE = 3'd5
    } state_t;

    // Packed so that a table word reads as {y,x}
    typedef struct packed {
        logic signed [ENV_WORLD_BITS-1:0] y;
        logic signed [ENV_WORLD_BITS-1:0] x;
    } vertex_t;

endpackage

// File: rtl/polygon_edge_streamer.sv
// Walks the polygon table and streams each polygon's closed edge loop downstream.
module polygon_edge_streamer
    import polygon_edge_streamer_pkg::*;
#(
    parameter int unsigned WORLD_BITS             = 32,
    parameter int unsigned MAX_NUM_VERTICES       = 8,
    parameter int unsigned MAX_POLYGONS_ON_SCREEN = 8
) (
    input  logic                                                           clk_in,
    input  logic                                                           rst_in,
    input  logic                                                           start_in,
    input  logic [$clog2(MAX_POLYGONS_ON_SCREEN+1)-1:0]                    num_polygons_in,
    input  logic [MAX_POLYGONS_ON_SCREEN*$clog2(MAX_NUM_VERTICES+1)-1:0]   vertex_counts_in,
    output logic                                                           rd_en_out,
    output logic [$clog2(MAX_POLYGONS_ON_SCREEN*MAX_NUM_VERTICES)-1:0]     rd_addr_out,
    input  logic [2*WORLD_BITS-1:0]                                        rd_data_in,
    output logic [4*WORLD_BITS-1:0]                                        edge_out,
    output logic [$clog2(MAX_POLYGONS_ON_SCREEN)-1:0]                      poly_idx_out,
    output logic                                                           last_edge_out,
    output logic                                                           last_polygon_out,
    output logic                                                           valid_out,
    input  logic                                                           ready_in,
    output logic                                                           busy_out,
    output logic                                                           done_out
);

    localparam int unsigned VW = 2 * WORLD_BITS;
    localparam int unsigned NW = $clog2(MAX_POLYGONS_ON_SCREEN + 1);
    localparam int unsigned CW = $clog2(MAX_NUM_VERTICES + 1);
    localparam int unsigned AW = $clog2(MAX_POLYGONS_ON_SCREEN * MAX_NUM_VERTICES);
    localparam int unsigned PW = $clog2(MAX_POLYGONS_ON_SCREEN);

    state_t                                   state_q, state_d;
    logic [NW-1:0]                            num_q, num_d;
    logic [MAX_POLYGONS_ON_SCREEN-1:0][CW-1:0] cnt_q, cnt_d;
    logic [MAX_POLYGONS_ON_SCREEN-1:0][CW-1:0] counts_in_w;
    logic [NW-1:0]                            poly_q, poly_d;
    logic [CW-1:0]                            vert_q, vert_d;
    logic [VW-1:0]                            first_q, first_d;
    logic [VW-1:0]                            prev_q, prev_d;
    logic [2*VW-1:0]                          edge_q, edge_d;
    logic [PW-1:0]                            pidx_q, pidx_d;
    logic                                     last_edge_q, last_edge_d;
    logic                                     last_poly_q, last_poly_d;
    logic [AW-1:0]                            rd_addr_q, rd_addr_d;
    logic                                     rd_en_q, valid_q, busy_q, done_q;
    logic [CW-1:0]                            cur_cnt;
    logic                                     later_live;

    assign counts_in_w = vertex_counts_in;
    assign cur_cnt     = cnt_q[PW'(poly_q)];

    // Does any later polygon in range still have a drawable (>=3 vertex) loop?
    always_comb begin
        later_live = 1'b0;
        for (int p = 0; p < MAX_POLYGONS_ON_SCREEN; p++) begin
            if ((NW'(p) > poly_q) && (NW'(p) < num_q) && (cnt_q[PW'(p)] >= CW'(3))) begin
                later_live = 1'b1;
            end
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        poly_d      = poly_q;
        vert_d      = vert_q;
        first_d     = first_q;
        prev_d      = prev_q;
        edge_d      = edge_q;
        pidx_d      = pidx_q;
        last_edge_d = last_edge_q;
        last_poly_d = last_poly_q;
        rd_addr_d   = '0;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    num_d = (num_polygons_in > NW'(MAX_POLYGONS_ON_SCREEN))
                          ? NW'(MAX_POLYGONS_ON_SCREEN) : num_polygons_in;
                    for (int p = 0; p < MAX_POLYGONS_ON_SCREEN; p++) begin
                        cnt_d[PW'(p)] = (counts_in_w[PW'(p)] > CW'(MAX_NUM_VERTICES))
                                      ? CW'(MAX_NUM_VERTICES) : counts_in_w[PW'(p)];
                    end
                    poly_d  = '0;
                    vert_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (poly_q == num_q) begin
                    state_d = DONE;
                end else if (cur_cnt < CW'(3)) begin
                    poly_d = poly_q + NW'(1);
                end else begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = CAP;
            end
            CAP: begin
                if (vert_q == '0) begin
                    first_d = rd_data_in;
                    prev_d  = rd_data_in;
                    vert_d  = CW'(1);
                    state_d = READ;
                end else begin
                    edge_d      = {rd_data_in, prev_q};
                    prev_d      = rd_data_in;
                    pidx_d      = PW'(poly_q);
                    last_edge_d = 1'b0;
                    last_poly_d = 1'b0;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (ready_in) begin
                    if (last_edge_q) begin
                        poly_d  = poly_q + NW'(1);
                        vert_d  = '0;
                        state_d = SCAN;
                    end else if (vert_q == cur_cnt - CW'(1)) begin
                        edge_d      = {first_q, prev_q};
                        last_edge_d = 1'b1;
                        last_poly_d = ~later_live;
                    end else begin
                        vert_d  = vert_q + CW'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == READ) begin
            rd_addr_d = AW'(32'(poly_d) * MAX_NUM_VERTICES + 32'(vert_d));
        end
    end

    // State register plus registered outputs derived from the next state
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            num_q       <= '0;
            cnt_q       <= '0;
            poly_q      <= '0;
            vert_q      <= '0;
            first_q     <= '0;
            prev_q      <= '0;
            edge_q      <= '0;
            pidx_q      <= '0;
            last_edge_q <= 1'b0;
            last_poly_q <= 1'b0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            poly_q      <= poly_d;
            vert_q      <= vert_d;
            first_q     <= first_d;
            prev_q      <= prev_d;
            edge_q      <= edge_d;
            pidx_q      <= pidx_d;
            last_edge_q <= last_edge_d;
            last_poly_q <= last_poly_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= (state_d == READ);
            valid_q     <= (state_d == EMIT);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign rd_en_out        = rd_en_q;
    assign rd_addr_out      = rd_addr_q;
    assign edge_out         = edge_q;
    assign poly_idx_out     = pidx_q;
    assign last_edge_out    = last_edge_q;
    assign last_polygon_out = last_poly_q;
    assign valid_out        = valid_q;
    assign busy_out         = busy_q;
    assign done_out         = done_q;

endmodule
